// File: rtl/int_bus_pkg.sv
// Shared definitions for the two-master register-file bus arbiter.
// State encoding, one-hot owner codes and default bus widths.
package int_bus_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    function automatic logic [1:0] owner_of(input arb_state_t st);
        case (st)
            ST_OWN0: owner_of = OWNER_M0;
            ST_OWN1: owner_of = OWNER_M1;
            default: owner_of = OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/int_bus_arbiter_hold_watchdog.sv
// Purpose: saturating count of cycles the owner holds the bus while the other master waits.
// Latency: count and sticky hold_timeout update on the edge where enable is sampled.
// Backpressure: none; purely diagnostic, never affects the grant.
module hold_watchdog #(
    parameter int HOLD_LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic hold_timeout
);

    localparam int CW = $clog2(HOLD_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(HOLD_LIMIT);

    logic [CW-1:0] count;
    logic          at_limit;

    assign at_limit = (count == LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            hold_timeout <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_limit) begin
            count <= count + 1'b1;
            // Flag rises together with the count reaching the limit.
            if (count == LIMIT - 1'b1) begin
                hold_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_bus_arbiter.sv
// Purpose: round-robin arbiter sharing the register-file bus between two masters.
// Latency: grant one cycle after req is sampled in IDLE; bus mux is combinational.
// Backpressure: a master waits on gnt; owner keeps the bus while its req stays high.
module int_bus_arbiter
    import int_bus_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int HOLD_LIMIT = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m1_req,
    output logic          m0_gnt,
    output logic          m1_gnt,
    input  logic [AW-1:0] m0_address,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m0_wr_data,
    input  logic [DW-1:0] m1_wr_data,
    input  logic          m0_write,
    input  logic          m1_write,
    input  logic          m0_read,
    input  logic          m1_read,
    output logic [DW-1:0] m0_rd_data,
    output logic [DW-1:0] m1_rd_data,
    output logic [AW-1:0] bus_address,
    output logic [DW-1:0] bus_wr_data,
    output logic          bus_write,
    output logic          bus_read,
    input  logic [DW-1:0] bus_rd_data,
    output logic [1:0]    owner,
    output logic          hold_timeout,
    output logic          proto_err
);

    typedef struct packed {
        logic [AW-1:0] address;
        logic [DW-1:0] wr_data;
        logic          write;
        logic          read;
    } bus_cmd_t;

    arb_state_t state, state_nxt;
    logic       last_m1, last_m1_nxt;
    bus_cmd_t   m0_cmd, m1_cmd, bus_cmd;
    logic       wd_enable, wd_clear;

    assign m0_cmd = '{address: m0_address, wr_data: m0_wr_data, write: m0_write, read: m0_read};
    assign m1_cmd = '{address: m1_address, wr_data: m1_wr_data, write: m1_write, read: m1_read};

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
        end
    end

    // No direct OWN0<->OWN1 path: every handover passes through one IDLE cycle.
    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        case (state)
            ST_IDLE: begin
                if (m0_req && (!m1_req || last_m1)) begin
                    state_nxt   = ST_OWN0;
                    last_m1_nxt = 1'b0;
                end else if (m1_req) begin
                    state_nxt   = ST_OWN1;
                    last_m1_nxt = 1'b1;
                end
            end
            ST_OWN0: if (!m0_req) state_nxt = ST_IDLE;
            ST_OWN1: if (!m1_req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        bus_cmd = '0;
        case (state)
            ST_OWN0: begin
                m0_gnt  = 1'b1;
                bus_cmd = m0_cmd;
            end
            ST_OWN1: begin
                m1_gnt  = 1'b1;
                bus_cmd = m1_cmd;
            end
            default: ;
        endcase
        owner = owner_of(state);
    end

    assign bus_address = bus_cmd.address;
    assign bus_wr_data = bus_cmd.wr_data;
    assign bus_write   = bus_cmd.write;
    assign bus_read    = bus_cmd.read;

    assign m0_rd_data = bus_rd_data;
    assign m1_rd_data = bus_rd_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (((m0_write || m0_read) && !m0_gnt) ||
                     ((m1_write || m1_read) && !m1_gnt)) begin
            proto_err <= 1'b1;
        end
    end

    assign wd_enable = ((state == ST_OWN0) && m1_req) || ((state == ST_OWN1) && m0_req);
    assign wd_clear  = (state == ST_IDLE);

    hold_watchdog #(
        .HOLD_LIMIT(HOLD_LIMIT)
    ) u_hold_watchdog (
        .clock       (clock),
        .reset       (reset),
        .enable      (wd_enable),
        .clear       (wd_clear),
        .hold_timeout(hold_timeout)
    );

endmodule

// File: tb/tb_int_bus_arbiter.sv
// Directed bench for int_bus_arbiter with a short hold limit.
module tb_int_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          m0_req, m1_req;
    logic          m0_gnt, m1_gnt;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_write, m1_write, m0_read, m1_read;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic [AW-1:0] bus_address;
    logic [DW-1:0] bus_wr_data;
    logic          bus_write, bus_read;
    logic [DW-1:0] bus_rd_data;
    logic [1:0]    owner;
    logic          hold_timeout, proto_err;

    int total = 0;
    int bad   = 0;

    int_bus_arbiter #(.AW(AW), .DW(DW), .HOLD_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_address(m0_address), .m1_address(m1_address),
        .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_read(m0_read), .m1_read(m1_read),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
        .bus_address(bus_address), .bus_wr_data(bus_wr_data),
        .bus_write(bus_write), .bus_read(bus_read),
        .bus_rd_data(bus_rd_data),
        .owner(owner), .hold_timeout(hold_timeout), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m1_req = 0;
        m0_address = 16'h0012; m0_wr_data = 8'hA5;
        m1_address = 16'h0BEE; m1_wr_data = 8'h5A;
        m0_write = 0; m1_write = 0; m0_read = 0; m1_read = 0;
        bus_rd_data = 8'h00;
        step();
        step();

        // Reset state, bus must be zero even with master inputs driven
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_owner", owner, 2'b00);
        chk("rst_hold", hold_timeout, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_bus_addr", bus_address, 0);
        chk("rst_bus_wdat", bus_wr_data, 0);

        // Single request from m0
        reset = 0;
        m0_req = 1;
        #1 chk("m0_gnt_not_yet", m0_gnt, 0);
        step();
        chk("m0_gnt_rise", m0_gnt, 1);
        chk("m0_owner", owner, 2'b01);
        m0_write = 1;
        #1;
        chk("wr_bus_write", bus_write, 1);
        chk("wr_bus_addr", bus_address, 16'h0012);
        chk("wr_bus_wdat", bus_wr_data, 8'hA5);
        chk("wr_bus_read", bus_read, 0);
        step();
        m0_write = 0;
        bus_rd_data = 8'h3C;
        #1;
        chk("rd_m0", m0_rd_data, 8'h3C);
        chk("rd_m1", m1_rd_data, 8'h3C);
        chk("no_proto_owner", proto_err, 0);
        m0_req = 0;
        step();
        chk("m0_release", m0_gnt, 0);
        chk("release_owner", owner, 2'b00);

        // Round-robin ties starting from reset
        reset = 1;
        step();
        reset = 0;
        m0_req = 1; m1_req = 1;
        step();
        chk("tie1_m0", m0_gnt, 1);
        chk("tie1_m1", m1_gnt, 0);
        m0_req = 0;
        step();
        chk("turn_owner", owner, 2'b00);
        chk("turn_m1", m1_gnt, 0);
        m0_req = 1;
        step();
        chk("tie2_m1", m1_gnt, 1);
        chk("tie2_m0", m0_gnt, 0);
        m1_req = 0;
        step();
        chk("tie2_idle", owner, 2'b00);
        m1_req = 1;
        step();
        chk("tie3_m0", owner, 2'b01);
        m0_req = 0;
        step();
        step();
        chk("m1_after_turn", owner, 2'b10);
        chk("no_hold_short", hold_timeout, 0);

        // m1 holds while m0 waits: flag after 4 waiting edges
        m0_req = 1;
        step(); step(); step();
        chk("hold_3", hold_timeout, 0);
        step();
        chk("hold_4", hold_timeout, 1);
        chk("hold_keeps_gnt", m1_gnt, 1);
        step();
        chk("hold_still_gnt", m1_gnt, 1);
        m1_req = 0;
        step();
        chk("hold_sticky_idle", hold_timeout, 1);
        step();
        chk("m0_after_hold", m0_gnt, 1);
        chk("hold_sticky_m0", hold_timeout, 1);

        // Non-owner read is blocked and flagged
        m1_read = 1;
        #1;
        chk("blk_bus_read", bus_read, 0);
        chk("blk_bus_addr", bus_address, 16'h0012);
        chk("proto_before", proto_err, 0);
        step();
        m1_read = 0;
        chk("proto_set", proto_err, 1);

        // Reset mid-grant with m0_req held
        reset = 1;
        step();
        chk("midrst_gnt", m0_gnt, 0);
        chk("midrst_owner", owner, 2'b00);
        chk("midrst_hold", hold_timeout, 0);
        chk("midrst_proto", proto_err, 0);
        reset = 0;
        step();
        chk("regrant_m0", m0_gnt, 1);

        // One-cycle pulse on m1, strobe forwarded in the release cycle
        m0_req = 0;
        step();
        m1_req = 1;
        step();
        m1_req = 0;
        m1_write = 1;
        #1;
        chk("pulse_gnt", m1_gnt, 1);
        chk("pulse_bus_write", bus_write, 1);
        chk("pulse_bus_addr", bus_address, 16'h0BEE);
        chk("pulse_bus_wdat", bus_wr_data, 8'h5A);
        step();
        m1_write = 0;
        chk("pulse_drop", m1_gnt, 0);
        chk("pulse_no_proto", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
